logic_unit_mc: RTL
==================

# logic_unit_mc

Multi-cycle 32-bit bitwise logic unit for the ALU datapath: accepts two 32-bit operands and an opcode, then evaluates AND/OR/XOR/NOR one byte per cycle, LSB byte first. It is the sequential, handshaked counterpart to the single-cycle gate-level bitwise arrays and is used by the multicycle datapath controller.
- Result and optional zero flag are registered and stable between operations.

## Interface
- No parameters; width is fixed at 32 bits, processed as 4 byte slices.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only when the unit can accept (IDLE or DONE).
- op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR; captured with start.
- in1  input  32  operand A; captured with start.
- in2  input  32  operand B; captured with start.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse: out/zero now hold the new result.
- out  output  32  registered result of the last completed operation.
- zero  output  1  registered flag, out == 0 (see Configuration).

## Operation
- States: IDLE, RUN, DONE. Internal: opA, opB (32), opc (2), acc (32), idx (2-bit byte counter).
- Reset (async, any state): state=IDLE, idx=0, acc=0, opA=opB=0, opc=0; outputs busy=0, done=0, out=0, zero=0. Reset mid-RUN abandons the operation; no done is produced.
- IDLE: start=1 -> capture in1/in2/op, idx=0, acc=0, go RUN. start=0 -> stay.
- RUN: each cycle acc[8*idx+7 : 8*idx] <= f(opc, opA byte idx, opB byte idx); idx increments. When idx==3 on that edge: out <= full result (acc with byte 3 merged), zero updated, go DONE.
- DONE: done=1 for exactly this cycle. start=1 -> capture new operands, go RUN (back-to-back). start=0 -> IDLE.
- start while in RUN is ignored (no queuing); in1/in2/op changes during RUN have no effect.
- out and zero change only on the RUN->DONE edge; never show partial results.
- idx wraps 3->0 naturally; it is reset to 0 on every accepted start.
- NOR is ~(a|b) per bit; all ops are pure bitwise, no carry between bytes.

## Timing
- Edge E0 samples start=1 (IDLE/DONE) -> busy=1 from E0.
- Edges E1..E4 process bytes 0..3; at E4 out/zero update, busy=0, done=1.
- Edge E5: done=0 (single-cycle pulse).
- Latency start-sample to done: 4 cycles; throughput: one operation per 5 cycles with start held high.
- busy and done are registered state decodes; never high together.

## Configuration
- LMC_ZERO_FLAG_EN defined: zero register present, loaded at E4 with (result == 32'h0).
- Not defined: zero register omitted, zero tied to constant 0 in every state.

## Test plan
- Reset with start=1 held: busy=0, done=0, out=0, zero=0; assert rst mid-RUN (after E2) -> busy drops immediately, no done pulse, out unchanged from 0.
- op=00, in1=32'hF0F0_1234, in2=32'h0FF0_FF00, start one cycle -> busy for 4 cycles, then done for 1 cycle, out=32'h00F0_1200, zero=0.
- op=01, 32'h1200_0000 | 32'h0000_0034 -> out=32'h1200_0034; op=10, 32'hAAAA_AAAA ^ 32'hAAAA_AAAA -> out=0, zero=1 (with LMC_ZERO_FLAG_EN; zero=0 without).
- op=11, in1=32'h0000_FFFF, in2=32'h00FF_0000 -> out=32'hFF00_0000; out holds previous value until the done cycle.
- start held high continuously, operands changed every cycle: captures only at E0 and at each DONE cycle; done every 5th cycle; results match operands sampled at those edges.
- start pulsed during RUN with different operands: ignored; result matches originally captured operands.

Source files
------------

// File: rtl/logic_unit_mc_if.sv
// Operand/result bundle for logic_unit_mc: the requester drives start/op/in1/in2,
// and the unit returns busy/done/out/zero.
interface logic_unit_mc_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic        zero;

  modport master (
    output start, op, in1, in2,
    input  busy, done, out, zero
  );

  modport slave (
    input  start, op, in1, in2,
    output busy, done, out, zero
  );
endinterface

// File: rtl/logic_unit_mc.sv
// Multi-cycle 32-bit AND/OR/XOR/NOR unit that evaluates one byte per cycle, LSB byte first.
// Define LMC_ZERO_FLAG_EN to register the zero flag; otherwise zero is tied to 0.
module logic_unit_mc (
  input  logic             clk,
  input  logic             rst,
  logic_unit_mc_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e      state_q;
  logic [31:0] opa_q, opb_q, acc_q, out_q;
  logic [1:0]  opc_q, idx_q;
  logic        busy_q, done_q;

  logic [7:0]  a_byte, b_byte, r_byte;
  logic [31:0] result_d;
  logic        last_byte;

  always_comb begin
    a_byte = opa_q[{idx_q, 3'b000} +: 8];
    b_byte = opb_q[{idx_q, 3'b000} +: 8];
    case (opc_q)
      2'b00:   r_byte = a_byte & b_byte;
      2'b01:   r_byte = a_byte | b_byte;
      2'b10:   r_byte = a_byte ^ b_byte;
      default: r_byte = ~(a_byte | b_byte);
    endcase
    // The final byte is merged combinationally so out never sees a partial result.
    result_d         = acc_q;
    result_d[31:24]  = r_byte;
    last_byte        = (state_q == RUN) && (idx_q == 2'd3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      opc_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            opa_q   <= bus.in1;
            opb_q   <= bus.in2;
            opc_q   <= bus.op;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          acc_q[{idx_q, 3'b000} +: 8] <= r_byte;
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            out_q   <= result_d;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LMC_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (last_byte) begin
      zero_q <= (result_d == '0);
    end
  end

  assign bus.zero = zero_q;
`else
  logic unused_last;
  assign unused_last = last_byte;
  assign bus.zero    = 1'b0;
`endif

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;
endmodule
